siso_shift_ctrl: RTL
====================

Name: siso_shift_ctrl

Overview:
- Frame controller that sequences a serial-in serial-out shift register: accepts a parallel word over a valid/ready handshake and streams it one bit per clock on a serial data line with a shift enable.
- Sits between a word-level producer and the siso datapath.
  - `d_out` drives the register's D input.
  - `shift_en` gates its clock-enable.
  - `frame` marks valid serial bits for downstream capture.

Parameters:
- WIDTH, 8, word length in bits; must be >= 2.
- GAP_CYCLES, 1, idle cycles inserted after each frame before the next word is accepted; 0 allowed.
- MSB_FIRST, 1, 1 = transmit in_data[WIDTH-1] first; 0 = transmit in_data[0] first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  parallel word; sampled only on handshake.
- in_ready  output  1  controller can accept a word.
- d_out  output  1  serial bit to siso D input.
- shift_en  output  1  shift register enable; high exactly when d_out carries a frame bit.
- frame  output  1  high for every bit of the current frame.
- busy  output  1  high from the cycle after acceptance until return to IDLE.
- done  output  1  one-cycle pulse after the last frame bit.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - Ports are clk and rst.
  - All state is updated on the rising edge of clk.
- Reset (rst=1 at an edge): state <- IDLE, bit counter <- 0, data buffer <- 0.
  - All outputs are 0, including in_ready.
  - in_ready goes to 1 in the first cycle with rst=0.
- Reset mid-frame aborts immediately: the next cycle has shift_en=frame=busy=done=0 and no done pulse.
- States: IDLE, SHIFT, GAP, plus PARITY when the optional feature is compiled in.
- IDLE:
  - in_ready=1; all other outputs 0, except done as noted below.
  - When in_valid=1, capture in_data into the buffer, clear the counter and go to SHIFT.
- SHIFT:
  - shift_en=1, frame=1, busy=1.
  - d_out = buffer bit selected by the counter and MSB_FIRST.
  - Counter increments each cycle.
  - When counter == WIDTH-1, go to PARITY if enabled, else to GAP. If GAP_CYCLES=0, go to IDLE instead of GAP.
- GAP: shift_en=frame=d_out=0, busy=1. Hold for GAP_CYCLES cycles, then go to IDLE.
- done: asserted for exactly one cycle, the cycle immediately after the last frame bit.
  - This is the first GAP cycle.
  - If GAP_CYCLES=0, it is the first IDLE cycle, with in_ready=1.
- Latency, with the handshake at the edge ending cycle k:
  - First bit appears in cycle k+1.
  - Last data bit appears in cycle k+WIDTH.
  - Next handshake is possible at the end of cycle k+WIDTH+GAP_CYCLES+1, or one cycle later with parity.
- Output timing:
  - in_ready is decoded from the state register only; there is no combinational path from in_valid.
  - All other outputs are registered or state-decoded; glitch-free per cycle.
- in_valid while not in IDLE is ignored; the producer holds the word until in_ready.
- Changes to in_data after acceptance have no effect.
- Counter width is $clog2(WIDTH); it must not wrap inside a frame.
- A continuously asserted in_valid yields back-to-back frames at the minimum spacing with no lost or duplicated words.

Optional Feature:
- Macro: SISO_PARITY_EN.
- When defined, the PARITY state follows the last data bit for one cycle.
  - shift_en=1, frame=1, busy=1.
  - d_out = XOR of all WIDTH captured bits (even parity).
  - done then moves one cycle later and the frame length is WIDTH+1.
- When undefined, there is no PARITY state, no extra cycle and no parity logic.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 -> all outputs 0, nothing accepted; in_ready=1 in the first cycle after release.
2. WIDTH=8, MSB_FIRST=1, GAP_CYCLES=1, send 8'hE9 -> d_out = 1,1,1,0,1,0,0,1 over 8 consecutive cycles with shift_en=frame=1; done=1 in the following cycle; in_ready=1 one cycle later.
3. MSB_FIRST=0, send 8'hE9 -> d_out = 1,0,0,1,0,1,1,1; shift_en asserted exactly 8 cycles.
4. in_valid held high with 8'hA5 then 8'h3C -> second handshake exactly 10 cycles after the first (11 with SISO_PARITY_EN); serial stream = A5 bits, one 0 gap cycle, 3C bits.
5. rst asserted after the 3rd bit of 8'hFF -> next cycle shift_en=frame=busy=0; no done pulse; a fresh 8'h81 afterwards transmits 1,0,0,0,0,0,0,1 cleanly.
6. SISO_PARITY_EN defined, send 8'hE9 (five ones) -> 9th bit d_out=1 with shift_en=1; send 8'h03 -> 9th bit 0; done one cycle after the 9th bit.

Source files
------------

// File: rtl/siso_shift_ctrl.sv
// Frame controller for a serial-in serial-out shift register: takes a word over valid/ready
// and streams it one bit per clock. Define SISO_PARITY_EN to append an even-parity bit.
module siso_shift_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             d_out,
  output logic             shift_en,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SISO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StGap, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [CntW-1:0]  bit_idx;
  state_e           after_frame;

  assign after_frame = (GAP_CYCLES == 0) ? StIdle : StGap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Explicit clear keeps non-power-of-two widths from running past the frame.
          cnt_d = '0;
`ifdef SISO_PARITY_EN
          state_d = StParity;
`else
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = after_frame;
`endif
        end
      end
`ifdef SISO_PARITY_EN
      StParity: begin
        done_d  = 1'b1;
        gap_d   = '0;
        state_d = after_frame;
      end
`endif
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bit_idx = (MSB_FIRST != 0) ? (CntLast - cnt_q) : cnt_q;

  always_comb begin
    d_out    = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      StShift: begin
        d_out    = data_q[bit_idx];
        shift_en = 1'b1;
      end
`ifdef SISO_PARITY_EN
      StParity: begin
        d_out    = ^data_q;
        shift_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // rst gate keeps in_ready low for every cycle reset is held, not only the first.
  assign in_ready = (state_q == StIdle) && !rst;
  assign frame    = shift_en;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

endmodule
